// File: rtl/cr_huf_comp_sm_drain.sv
// cr_huf_comp_sm_drain: drains an upstream FIFO into 1- or 2-entry output words, pairing entries where possible
module cr_huf_comp_sm_drain #(
    parameter int WIDTH = 55,
    parameter int DEPTH = 6,
    parameter int STALL_MAX = 15,
    localparam int UW = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fifo_empty,
    input  logic [UW-1:0]      fifo_used_slots,
    input  logic [WIDTH-1:0]   fifo_rdata,
    input  logic [WIDTH-1:0]   fifo_rdata_nxt,
    output logic               fifo_ren,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_data,
    output logic [1:0]         out_cnt,
    output logic               out_last,
    output logic [15:0]        pair_count
);
    localparam int SW = $clog2(STALL_MAX + 2);
    typedef enum logic {IDLE, POP2} state_t;
    state_t state, state_nxt;
    logic [SW-1:0] stall, stall_nxt;
    logic free, load, last_nxt;
    logic [2*WIDTH-1:0] data_nxt;
    logic [1:0] cnt_nxt;
    always_comb begin
        free = !out_valid | out_ready;
        state_nxt = state;
        stall_nxt = '0;
        load = 1'b0;
        fifo_ren = 1'b0;
        data_nxt = '0;
        cnt_nxt = 2'd0;
        last_nxt = 1'b0;
        if (state == POP2) begin
            fifo_ren = 1'b1;
            state_nxt = IDLE;
        end else if (free && !fifo_empty) begin
            if (fifo_rdata[WIDTH-1]) begin
                load = 1'b1;
                fifo_ren = 1'b1;
                data_nxt = {fifo_rdata, {WIDTH{1'b0}}};
                cnt_nxt = 2'd1;
                last_nxt = 1'b1;
            end else if (fifo_used_slots >= UW'(2)) begin
                load = 1'b1;
                fifo_ren = 1'b1;
                data_nxt = {fifo_rdata, fifo_rdata_nxt};
                cnt_nxt = 2'd2;
                last_nxt = fifo_rdata_nxt[WIDTH-1];
                state_nxt = POP2;
            end else if (stall == SW'(STALL_MAX)) begin
                load = 1'b1;
                fifo_ren = 1'b1;
                data_nxt = {fifo_rdata, {WIDTH{1'b0}}};
                cnt_nxt = 2'd1;
            end else begin
                stall_nxt = stall + SW'(1);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            stall <= '0;
            out_valid <= 1'b0;
            out_data <= '0;
            out_cnt <= 2'd0;
            out_last <= 1'b0;
            pair_count <= 16'd0;
        end else begin
            state <= state_nxt;
            stall <= stall_nxt;
            if (out_valid && out_ready && out_cnt == 2'd2 && pair_count != 16'hFFFF)
                pair_count <= pair_count + 16'd1;
            if (load) begin
                out_valid <= 1'b1;
                out_data <= data_nxt;
                out_cnt <= cnt_nxt;
                out_last <= last_nxt;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cr_huf_comp_sm_drain.sv
// tb_cr_huf_comp_sm_drain: scoreboard bench with a queue-modelled FIFO and burst-level grouping model
module tb_cr_huf_comp_sm_drain;
    localparam int W = 55;
    localparam int D = 6;
    localparam int SM = 15;
    localparam int UW = $clog2(D + 1);
    typedef struct {
        logic [2*W-1:0] d;
        logic [1:0] c;
        logic l;
    } word_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic fifo_empty;
    logic [UW-1:0] fifo_used_slots;
    logic [W-1:0] fifo_rdata, fifo_rdata_nxt;
    logic fifo_ren, out_valid, out_ready, out_last;
    logic [2*W-1:0] out_data, held;
    logic [1:0] out_cnt;
    logic [15:0] pair_count;
    logic [W-1:0] q[$];
    logic [W-1:0] bq[$];
    word_t sb[$];
    word_t mon_w;
    int errors = 0, checks = 0, acc_n = 0, model_pc = 0;
    bit rand_ready = 1'b0;
    logic ren_s, v_s;
    logic [2:0] r;
    int n, pops, a0;
    bit have;

    always #5 clk = ~clk;

    cr_huf_comp_sm_drain #(.WIDTH(W), .DEPTH(D), .STALL_MAX(SM)) dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_used_slots(fifo_used_slots),
        .fifo_rdata(fifo_rdata), .fifo_rdata_nxt(fifo_rdata_nxt), .fifo_ren(fifo_ren),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_cnt(out_cnt),
        .out_last(out_last), .pair_count(pair_count)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] ent(input bit last);
        logic [W-1:0] e;
        e = W'({$urandom(), $urandom()});
        e[W-1] = last;
        return e;
    endfunction

    task automatic drive();
        fifo_empty = q.size() == 0;
        fifo_used_slots = UW'(q.size());
        fifo_rdata = q.size() > 0 ? q[0] : '0;
        fifo_rdata_nxt = q.size() > 1 ? q[1] : '0;
    endtask

    task automatic tick();
        @(negedge clk);
        ren_s = fifo_ren;
        v_s = out_valid;
        @(posedge clk);
        #1;
        if (ren_s && q.size() > 0) q.delete(0);
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        drive();
    endtask

    // The whole burst is present at once, so grouping follows from order alone:
    // LAST head goes single, otherwise pair if a follower exists, else a lone timeout single.
    task automatic push();
        word_t w;
        int i = 0;
        while (i < bq.size()) begin
            if (bq[i][W-1]) begin
                w.d = {bq[i], {W{1'b0}}}; w.c = 2'd1; w.l = 1'b1; i++;
            end else if (i + 1 < bq.size()) begin
                w.d = {bq[i], bq[i+1]}; w.c = 2'd2; w.l = bq[i+1][W-1]; i += 2;
            end else begin
                w.d = {bq[i], {W{1'b0}}}; w.c = 2'd1; w.l = 1'b0; i++;
            end
            sb.push_back(w);
        end
        foreach (bq[k]) q.push_back(bq[k]);
        drive();
    endtask

    task automatic wait_idle();
        int k = 0;
        while (!(q.size() == 0 && sb.size() == 0 && !out_valid) && k < 500) begin
            tick();
            k++;
        end
        check("drain_timeout", 128'(k >= 500), 128'(0));
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("ren_while_empty", 128'(fifo_ren && fifo_empty), 128'(0));
            if (out_valid && out_ready) begin
                acc_n++;
                if (sb.size() == 0) begin
                    check("unexpected_word", 128'(1), 128'(0));
                end else begin
                    mon_w = sb.pop_front();
                    check("word", {out_data, out_cnt, out_last}, {mon_w.d, mon_w.c, mon_w.l});
                    check("pair_count", 128'(pair_count), 128'(model_pc));
                    if (mon_w.c == 2'd2) model_pc++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        out_ready = 1'b1;
        drive();
        repeat (3) tick();
        check("rst_valid", 128'(out_valid), 128'(0));
        check("rst_cnt", 128'(out_cnt), 128'(0));
        check("rst_last", 128'(out_last), 128'(0));
        check("rst_data", 128'(out_data), 128'(0));
        check("rst_pair_count", 128'(pair_count), 128'(0));
        check("rst_ren", 128'(fifo_ren), 128'(0));
        rst = 1'b0;
        tick();

        bq = {ent(0), ent(0)};
        push();
        tick(); r[2] = ren_s;
        tick(); r[1] = ren_s;
        tick(); r[0] = ren_s;
        check("pair_ren_pattern", 128'(r), 128'(3'b110));
        wait_idle();
        check("pair_count_one", 128'(pair_count), 128'(1));

        bq = {ent(1)};
        push();
        tick(); r[1] = ren_s;
        tick(); r[0] = ren_s;
        check("last_ren_pattern", 128'(r[1:0]), 128'(2'b10));
        wait_idle();

        bq = {ent(0)};
        push();
        n = 0;
        while (n < 100) begin
            tick();
            if (v_s) break;
            n++;
        end
        check("timeout_latency", 128'(n), 128'(SM + 1));
        wait_idle();

        bq = {ent(0), ent(1)};
        push();
        wait_idle();
        check("pair_count_two", 128'(pair_count), 128'(2));

        out_ready = 1'b0;
        bq.delete();
        repeat (6) bq.push_back(ent(0));
        push();
        pops = 0;
        have = 1'b0;
        repeat (10) begin
            tick();
            pops += int'(ren_s);
            if (v_s) begin
                if (!have) begin
                    held = out_data;
                    have = 1'b1;
                end else begin
                    check("bp_hold_data", 128'(out_data), 128'(held));
                end
            end
        end
        check("bp_pops_at_most_2", 128'(pops <= 2), 128'(1));
        check("bp_valid_held", 128'(out_valid), 128'(1));
        out_ready = 1'b1;
        a0 = acc_n;
        repeat (6) tick();
        check("bp_release_words", 128'(acc_n - a0), 128'(3));
        wait_idle();
        check("pair_count_five", 128'(pair_count), 128'(5));

        rand_ready = 1'b1;
        repeat (40) begin
            bq.delete();
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) bq.push_back(ent($urandom_range(0, 3) == 0));
            push();
            wait_idle();
        end
        rand_ready = 1'b0;
        out_ready = 1'b1;
        tick();
        check("pair_count_random", 128'(pair_count), 128'(model_pc));

        bq = {ent(0), ent(0)};
        push();
        tick();
        rst = 1'b1;
        sb.delete();
        tick();
        q.delete();
        drive();
        @(negedge clk);
        check("pop2_rst_ren", 128'(fifo_ren), 128'(0));
        check("pop2_rst_valid", 128'(out_valid), 128'(0));
        check("pop2_rst_cnt", 128'(out_cnt), 128'(0));
        check("pop2_rst_pair_count", 128'(pair_count), 128'(0));
        model_pc = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bq = {ent(0), ent(0)};
        push();
        wait_idle();
        check("post_rst_pair_count", 128'(pair_count), 128'(1));
        check("sb_empty", 128'(sb.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
